// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/ASR/clear per cycle,
// plus a burst engine that repeats a shift mode amt times with busy/done.
module shift_reg_univ #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      AMT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_ASR  = 3'b110,
    M_CLR  = 3'b111
  } mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shiftable;

  // Bit loops instead of part-selects so WIDTH=1 degenerates cleanly
  // (rotates and ASR become holds, shifts take the serial input).
  function automatic logic [WIDTH-1:0] apply_op(
    input mode_t            op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = cur;
    case (op)
      M_LOAD: r = ld;
      M_SHL: begin
        r[0] = sr;
        for (int unsigned i = 1; i < WIDTH; i++) r[i] = cur[i-1];
      end
      M_SHR: begin
        r[WIDTH-1] = sl;
        for (int unsigned i = 0; i + 1 < WIDTH; i++) r[i] = cur[i+1];
      end
      M_ROL: begin
        r[0] = cur[WIDTH-1];
        for (int unsigned i = 1; i < WIDTH; i++) r[i] = cur[i-1];
      end
      M_ROR: begin
        r[WIDTH-1] = cur[0];
        for (int unsigned i = 0; i + 1 < WIDTH; i++) r[i] = cur[i+1];
      end
      M_ASR: begin
        r[WIDTH-1] = cur[WIDTH-1];
        for (int unsigned i = 0; i + 1 < WIDTH; i++) r[i] = cur[i+1];
      end
      M_CLR:   r = RESET_VALUE;
      default: r = cur;
    endcase
    return r;
  endfunction

  assign shiftable = (mode >= 3'b010) && (mode <= 3'b110);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (amt == '0) begin
            done_d = 1'b1;
          end else begin
            q_d = apply_op(mode_t'(mode), q_q, d, sin_l, sin_r);
            if (shiftable && (amt > AMT_W'(1))) begin
              mode_d  = mode_t'(mode);
              cnt_d   = amt - AMT_W'(1);
              state_d = BUSY;
            end else begin
              done_d = 1'b1;
            end
          end
        end else if (en) begin
          q_d = apply_op(mode_t'(mode), q_q, d, sin_l, sin_r);
        end
      end
      BUSY: begin
        q_d   = apply_op(mode_q, q_q, d, sin_l, sin_r);
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= M_HOLD;
      q_q     <= RESET_VALUE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign q      = q_q;
  assign q_n    = ~q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = (state_q == BUSY);
  assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ at WIDTH=8, 16 and 1: expected q/busy/done
// are queued when each cycle's stimulus is driven and popped after the edge.
module tb_shift_reg_univ;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, CLR = 3'd7;

  typedef struct packed {
    logic       rst, en, start;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl, sr;
    logic [3:0] amt;
    logic [7:0] eq;
    logic       eb, ed;
  } stim8_t;

  typedef struct packed {
    logic [15:0] q;
    logic        busy, done;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en8, sl8, sr8, start8, soutl8, soutr8, busy8, done8;
  logic [2:0] mode8;
  logic [7:0] d8, q8, qn8;
  logic [3:0] amt8;

  logic        en16, sl16, sr16, start16, soutl16, soutr16, busy16, done16;
  logic [2:0]  mode16;
  logic [15:0] d16, q16, qn16;
  logic [3:0]  amt16;

  logic       en1, sl1, sr1, start1, soutl1, soutr1, busy1, done1;
  logic [2:0] mode1;
  logic [0:0] d1, q1, qn1;
  logic [3:0] amt1;

  shift_reg_univ #(.WIDTH(8), .RESET_VALUE(8'hA5), .AMT_W(4)) u8 (
    .clk(clk), .reset(rst), .en(en8), .mode(mode8), .d(d8), .sin_l(sl8), .sin_r(sr8),
    .start(start8), .amt(amt8), .q(q8), .q_n(qn8), .sout_l(soutl8), .sout_r(soutr8),
    .busy(busy8), .done(done8));

  shift_reg_univ #(.WIDTH(16), .RESET_VALUE(16'h0000), .AMT_W(4)) u16 (
    .clk(clk), .reset(rst), .en(en16), .mode(mode16), .d(d16), .sin_l(sl16), .sin_r(sr16),
    .start(start16), .amt(amt16), .q(q16), .q_n(qn16), .sout_l(soutl16), .sout_r(soutr16),
    .busy(busy16), .done(done16));

  shift_reg_univ #(.WIDTH(1), .RESET_VALUE(1'b1), .AMT_W(4)) u1 (
    .clk(clk), .reset(rst), .en(en1), .mode(mode1), .d(d1), .sin_l(sl1), .sin_r(sr1),
    .start(start1), .amt(amt1), .q(q1), .q_n(qn1), .sout_l(soutl1), .sout_r(soutr1),
    .busy(busy1), .done(done1));

  function automatic stim8_t s(input logic r, input logic e, input logic st, input logic [2:0] m,
                               input logic [7:0] dd, input logic l, input logic rr,
                               input logic [3:0] a, input logic [7:0] eq, input logic eb,
                               input logic ed);
    return '{rst: r, en: e, start: st, mode: m, d: dd, sl: l, sr: rr, amt: a,
             eq: eq, eb: eb, ed: ed};
  endfunction

  task automatic test_reset();
    stim8_t t[$];
    exp_t   e;
    t.push_back(s(1, 1, 1, LOAD, 8'h00, 0, 0, 4'd3, 8'hA5, 0, 0));
    t.push_back(s(1, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0));
    t.push_back(s(0, 0, 0, LOAD, 8'h3C, 1, 1, 4'd0, 8'hA5, 0, 0));
    t.push_back(s(0, 0, 0, SHL,  8'h3C, 1, 1, 4'd0, 8'hA5, 0, 0));
    t.push_back(s(0, 0, 0, ROR,  8'h3C, 1, 1, 4'd0, 8'hA5, 0, 0));
    t.push_back(s(0, 0, 0, CLR,  8'h3C, 1, 1, 4'd0, 8'hA5, 0, 0));
    foreach (t[i]) begin
      rst = t[i].rst; en8 = t[i].en; start8 = t[i].start; mode8 = t[i].mode;
      d8 = t[i].d; sl8 = t[i].sl; sr8 = t[i].sr; amt8 = t[i].amt;
      sb.push_back('{q: {8'h00, t[i].eq}, busy: t[i].eb, done: t[i].ed});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (q8 !== e.q[7:0] || qn8 !== ~e.q[7:0] || soutl8 !== e.q[7] || soutr8 !== e.q[0] ||
          busy8 !== e.busy || done8 !== e.done) begin
        errors++;
        $display("FAIL test_reset[%0d]: q=%h q_n=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                 i, q8, qn8, busy8, done8, e.q[7:0], e.busy, e.done);
      end
    end
    checks++;
    if (q16 !== 16'h0000 || busy16 !== 1'b0 || done16 !== 1'b0 || q1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL test_reset_other: q16=%h busy16=%b done16=%b q1=%b busy1=%b, expected 0000 0 0 1 0",
               q16, busy16, done16, q1, busy1);
    end
  endtask

  task automatic test_single_step();
    stim8_t t[$];
    exp_t   e;
    t.push_back(s(0, 1, 0, LOAD, 8'h81, 0, 1, 4'd0, 8'h81, 0, 0));
    t.push_back(s(0, 1, 0, SHL,  8'h00, 0, 1, 4'd0, 8'h03, 0, 0));
    t.push_back(s(0, 1, 0, ROR,  8'h00, 0, 1, 4'd0, 8'h81, 0, 0));
    t.push_back(s(0, 1, 0, ASR,  8'h00, 0, 1, 4'd0, 8'hC0, 0, 0));
    t.push_back(s(0, 1, 0, SHR,  8'h00, 0, 1, 4'd0, 8'h60, 0, 0));
    t.push_back(s(0, 1, 0, ROL,  8'h00, 0, 1, 4'd0, 8'hC0, 0, 0));
    t.push_back(s(0, 1, 0, CLR,  8'h00, 0, 1, 4'd0, 8'hA5, 0, 0));
    foreach (t[i]) begin
      rst = t[i].rst; en8 = t[i].en; start8 = t[i].start; mode8 = t[i].mode;
      d8 = t[i].d; sl8 = t[i].sl; sr8 = t[i].sr; amt8 = t[i].amt;
      sb.push_back('{q: {8'h00, t[i].eq}, busy: t[i].eb, done: t[i].ed});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (q8 !== e.q[7:0] || qn8 !== ~e.q[7:0] || busy8 !== e.busy || done8 !== e.done) begin
        errors++;
        $display("FAIL test_single_step[%0d]: q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                 i, q8, busy8, done8, e.q[7:0], e.busy, e.done);
      end
    end
  endtask

  task automatic test_burst();
    stim8_t t[$];
    exp_t   e;
    t.push_back(s(0, 1, 0, LOAD, 8'h01, 0, 0, 4'd0, 8'h01, 0, 0));
    t.push_back(s(0, 0, 1, ROL,  8'h00, 0, 0, 4'd3, 8'h02, 1, 0));
    t.push_back(s(0, 1, 0, LOAD, 8'hFF, 1, 1, 4'd0, 8'h04, 1, 0));
    t.push_back(s(0, 1, 1, CLR,  8'hFF, 1, 1, 4'd9, 8'h08, 0, 1));
    t.push_back(s(0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h08, 0, 0));
    foreach (t[i]) begin
      rst = t[i].rst; en8 = t[i].en; start8 = t[i].start; mode8 = t[i].mode;
      d8 = t[i].d; sl8 = t[i].sl; sr8 = t[i].sr; amt8 = t[i].amt;
      sb.push_back('{q: {8'h00, t[i].eq}, busy: t[i].eb, done: t[i].ed});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (q8 !== e.q[7:0] || busy8 !== e.busy || done8 !== e.done) begin
        errors++;
        $display("FAIL test_burst[%0d]: q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                 i, q8, busy8, done8, e.q[7:0], e.busy, e.done);
      end
    end
  endtask

  task automatic test_start_edge();
    stim8_t t[$];
    exp_t   e;
    t.push_back(s(0, 0, 1, SHL,  8'h00, 0, 1, 4'd0, 8'h08, 0, 1));
    t.push_back(s(0, 0, 1, LOAD, 8'h3C, 0, 0, 4'd5, 8'h3C, 0, 1));
    foreach (t[i]) begin
      rst = t[i].rst; en8 = t[i].en; start8 = t[i].start; mode8 = t[i].mode;
      d8 = t[i].d; sl8 = t[i].sl; sr8 = t[i].sr; amt8 = t[i].amt;
      sb.push_back('{q: {8'h00, t[i].eq}, busy: t[i].eb, done: t[i].ed});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (q8 !== e.q[7:0] || busy8 !== e.busy || done8 !== e.done) begin
        errors++;
        $display("FAIL test_start_edge[%0d]: q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                 i, q8, busy8, done8, e.q[7:0], e.busy, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim8_t t[$];
    exp_t   e;
    t.push_back(s(0, 0, 1, ROR,  8'h00, 0, 0, 4'd2, 8'h1E, 1, 0));
    t.push_back(s(0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h0F, 0, 1));
    t.push_back(s(0, 0, 1, SHR,  8'h00, 1, 0, 4'd1, 8'h87, 0, 1));
    t.push_back(s(0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h87, 0, 0));
    foreach (t[i]) begin
      rst = t[i].rst; en8 = t[i].en; start8 = t[i].start; mode8 = t[i].mode;
      d8 = t[i].d; sl8 = t[i].sl; sr8 = t[i].sr; amt8 = t[i].amt;
      sb.push_back('{q: {8'h00, t[i].eq}, busy: t[i].eb, done: t[i].ed});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (q8 !== e.q[7:0] || busy8 !== e.busy || done8 !== e.done) begin
        errors++;
        $display("FAIL test_back_to_back[%0d]: q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                 i, q8, busy8, done8, e.q[7:0], e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset_midburst();
    stim8_t t[$];
    exp_t   e;
    t.push_back(s(0, 1, 0, LOAD, 8'h01, 0, 0, 4'd0, 8'h01, 0, 0));
    t.push_back(s(0, 0, 1, ROL,  8'h00, 0, 0, 4'd5, 8'h02, 1, 0));
    t.push_back(s(1, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0));
    t.push_back(s(0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0));
    t.push_back(s(0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0));
    t.push_back(s(0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0));
    t.push_back(s(0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0));
    t.push_back(s(0, 0, 1, ROL,  8'h00, 0, 0, 4'd2, 8'h4B, 1, 0));
    t.push_back(s(0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h96, 0, 1));
    t.push_back(s(0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h96, 0, 0));
    foreach (t[i]) begin
      rst = t[i].rst; en8 = t[i].en; start8 = t[i].start; mode8 = t[i].mode;
      d8 = t[i].d; sl8 = t[i].sl; sr8 = t[i].sr; amt8 = t[i].amt;
      sb.push_back('{q: {8'h00, t[i].eq}, busy: t[i].eb, done: t[i].ed});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (q8 !== e.q[7:0] || busy8 !== e.busy || done8 !== e.done) begin
        errors++;
        $display("FAIL test_reset_midburst[%0d]: q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                 i, q8, busy8, done8, e.q[7:0], e.busy, e.done);
      end
    end
  endtask

  // Serial inputs are sampled live on every burst edge.
  task automatic test_live_serial();
    stim8_t t[$];
    exp_t   e;
    t.push_back(s(0, 0, 1, SHL,  8'h00, 0, 1, 4'd3, 8'h2D, 1, 0));
    t.push_back(s(0, 0, 0, SHR,  8'h00, 1, 0, 4'd0, 8'h5A, 1, 0));
    t.push_back(s(0, 0, 0, HOLD, 8'h00, 0, 1, 4'd0, 8'hB5, 0, 1));
    t.push_back(s(0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'hB5, 0, 0));
    foreach (t[i]) begin
      rst = t[i].rst; en8 = t[i].en; start8 = t[i].start; mode8 = t[i].mode;
      d8 = t[i].d; sl8 = t[i].sl; sr8 = t[i].sr; amt8 = t[i].amt;
      sb.push_back('{q: {8'h00, t[i].eq}, busy: t[i].eb, done: t[i].ed});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (q8 !== e.q[7:0] || busy8 !== e.busy || done8 !== e.done) begin
        errors++;
        $display("FAIL test_live_serial[%0d]: q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                 i, q8, busy8, done8, e.q[7:0], e.busy, e.done);
      end
    end
  endtask

  task automatic test_wide();
    exp_t e;
    en16 = 1'b1; start16 = 1'b0; mode16 = LOAD; d16 = 16'h0001; sl16 = 1'b0; sr16 = 1'b0; amt16 = 4'd0;
    sb.push_back('{q: 16'h0001, busy: 1'b0, done: 1'b0});
    for (int i = 0; i < 17; i++) begin
      if (i == 1) begin
        en16 = 1'b0; start16 = 1'b1; mode16 = ROL; amt16 = 4'd15;
      end else if (i > 1) begin
        start16 = 1'b0; en16 = 1'b1; mode16 = CLR; d16 = 16'hFFFF;
      end
      if (i == 16) begin
        en16 = 1'b0; mode16 = HOLD;
      end
      if (i >= 1 && i <= 15)
        sb.push_back('{q: 16'h0001 << i, busy: (i < 15), done: (i == 15)});
      else if (i == 16)
        sb.push_back('{q: 16'h8000, busy: 1'b0, done: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (q16 !== e.q || qn16 !== ~e.q || soutl16 !== e.q[15] || soutr16 !== e.q[0] ||
          busy16 !== e.busy || done16 !== e.done) begin
        errors++;
        $display("FAIL test_wide[%0d]: q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                 i, q16, busy16, done16, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_width1();
    logic [2:0] md [11] = '{SHL, SHR, ROL, ROR, ASR, LOAD, ASR, CLR, SHL, HOLD, HOLD};
    logic       ex [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       eb [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       ed [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      mode1 = md[i]; d1 = 1'b0; sl1 = 1'b1; sr1 = 1'b0;
      en1 = (i < 8); start1 = (i == 8); amt1 = (i == 8) ? 4'd3 : 4'd0;
      sb.push_back('{q: {15'h0, ex[i]}, busy: eb[i], done: ed[i]});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (q1 !== e.q[0:0] || qn1 !== ~e.q[0:0] || soutl1 !== e.q[0] || soutr1 !== e.q[0] ||
          busy1 !== e.busy || done1 !== e.done) begin
        errors++;
        $display("FAIL test_width1[%0d]: q=%b busy=%b done=%b, expected q=%b busy=%b done=%b",
                 i, q1, busy1, done1, e.q[0], e.busy, e.done);
      end
    end
    en1 = 1'b0; start1 = 1'b0; mode1 = HOLD;
  endtask

  initial begin
    rst = 1'b1;
    en8 = 1'b0; start8 = 1'b0; mode8 = HOLD; d8 = '0; sl8 = 1'b0; sr8 = 1'b0; amt8 = '0;
    en16 = 1'b0; start16 = 1'b0; mode16 = HOLD; d16 = '0; sl16 = 1'b0; sr16 = 1'b0; amt16 = '0;
    en1 = 1'b0; start1 = 1'b0; mode1 = HOLD; d1 = '0; sl1 = 1'b0; sr1 = 1'b0; amt1 = '0;
    test_reset();
    test_single_step();
    test_burst();
    test_start_edge();
    test_back_to_back();
    test_reset_midburst();
    test_live_serial();
    test_wide();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal register: a WIDTH-bit bank of edge-triggered D storage with complementary outputs, per-cycle operation select (hold, load, shift, rotate, arithmetic shift, clear) and a multi-cycle burst-shift engine with busy/done handshake. It succeeds the single-bit master-slave D flip-flop as the team's general storage/shifting element. It is used wherever datapaths need loadable, shiftable state.

## Interface
- WIDTH, 8, register width in bits (>= 1)
- RESET_VALUE, {WIDTH{1'b0}}, value loaded on reset and by CLEAR
- AMT_W, 4, width of burst shift amount
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; priority over all other inputs
- en  in  1  single-step enable (IDLE only)
- mode  in  3  operation select
- d  in  WIDTH  parallel load data
- sin_l  in  1  serial in at MSB (SHR)
- sin_r  in  1  serial in at LSB (SHL)
- start  in  1  burst request (IDLE only)
- amt  in  AMT_W  burst shift count
- q  out  WIDTH  register contents
- q_n  out  WIDTH  ~q
- sout_l  out  1  q[WIDTH-1]
- sout_r  out  1  q[0]
- busy  out  1  burst in progress
- done  out  1  one-cycle completion pulse

## Operation
- Mode encoding: 000 HOLD; 001 LOAD q<=d; 010 SHL q<={q[W-2:0],sin_r}; 011 SHR q<={sin_l,q[W-1:1]}; 100 ROL; 101 ROR; 110 ASR q<={q[W-1],q[W-1:1]}; 111 CLEAR q<=RESET_VALUE.
- WIDTH=1: SHL->sin_r, SHR->sin_l, ROL/ROR/ASR hold.
- States: IDLE, BUSY. Reset -> IDLE.
- IDLE, start=1 (priority over en):
  - mode in 010..110 and amt>=2: apply mode once at this edge, latch mode, cnt<=amt-1, -> BUSY, busy<=1.
  - mode in 010..110 and amt=1: apply once, stay IDLE, done<=1.
  - amt=0 or mode in {000,001,111}: apply mode once (amt=0: no change to q), stay IDLE, done<=1.
- IDLE, start=0, en=1: apply mode once; done stays 0.
- IDLE, start=0, en=0: hold.
- BUSY: apply latched mode each edge, cnt<=cnt-1; at the edge where cnt=1, -> IDLE, busy<=0, done<=1.
- BUSY ignores en, mode, d, start, amt; sin_l/sin_r are sampled live each edge.
- done is high exactly one cycle, then cleared unless re-set by a new completion.
- Reset (any state): q<=RESET_VALUE, state IDLE, busy<=0, done<=0, cnt<=0.

## Timing
- Reset values: q=RESET_VALUE, q_n=~RESET_VALUE, sout_l/sout_r=corresponding bits, busy=0, done=0.
- q, busy, done are registered; q_n, sout_l, sout_r are combinational from q with no additional latency.
- Single step: result visible in q one edge after the sampling edge.
- Burst of amt=N>=2: start sampled at edge k; shifts occur at edges k..k+N-1; busy=1 after edges k..k+N-2; after edge k+N-1, busy=0, done=1, and q holds the final value.
- New start is accepted in the cycle where done=1 (state already IDLE), giving back-to-back bursts.
- amt is not range-limited: ROL/ROR with amt>=WIDTH wraps modulo WIDTH in effect; SHL/SHR/ASR saturate naturally.

## Test plan
- WIDTH=8, RESET_VALUE=8'hA5: hold reset 2 cycles -> q=A5, q_n=5A, sout_l=1, sout_r=1, busy=0, done=0; with en=0 and mode toggling, q stays A5.
- en=1: LOAD d=81 -> q=81; SHL sin_r=1 -> 03; ROR -> 81; ASR -> C0; SHR sin_l=0 -> 60; CLEAR -> A5; each result appears 1 cycle after its edge; done stays 0.
- q=01, start mode=ROL amt=3 -> q=02,04,08 on successive edges; busy high 2 cycles; done=1 with q=08. Mode/en/d changes during busy have no effect.
- start amt=0 -> done pulse, q unchanged, busy 0. start mode=LOAD d=3C -> q=3C, done pulse. Back-to-back start during the done cycle (ROR amt=2 from 3C) -> 0F.
- Burst ROL amt=5 from q=01; assert reset at the 2nd shift edge -> q=A5, busy=0, done=0, no done pulse ever; a fresh burst afterwards completes normally.
- WIDTH=16, q=0001, ROL amt=15 -> q=8000 after 15 edges, busy high 14 cycles; WIDTH=1 SHL sin_r=0 -> q=0.
